// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment display controller: periodically samples `result`,
// converts it to BCD (sequential shift-add-3) or hex digits, and scans the digits.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int UPDATE_DIV  = 100000000
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  hlt,
  input  logic                  test,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  // Smallest digit count whose decimal range covers 2^width - 1.
  function automatic int bcd_digits_for(input int width);
    longint unsigned max_val;
    longint unsigned pow;
    int              n;
    max_val = (64'd1 << width) - 64'd1;
    pow     = 64'd10;
    n       = 1;
    while (pow <= max_val) begin
      pow = pow * 64'd10;
      n++;
    end
    return n;
  endfunction

  localparam int BCD_DIGITS = bcd_digits_for(DATA_WIDTH);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int UPD_W      = $clog2(UPDATE_DIV);
  localparam int REF_W      = $clog2(REFRESH_DIV);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int CNT_W      = $clog2(DATA_WIDTH);

  localparam logic [4:0] G_S     = 5'd16;
  localparam logic [4:0] G_T     = 5'd17;
  localparam logic [4:0] G_O     = 5'd18;
  localparam logic [4:0] G_P     = 5'd19;
  localparam logic [4:0] G_DASH  = 5'd20;
  localparam logic [4:0] G_BLANK = 5'd21;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                  state;
  logic [UPD_W-1:0]        upd_cnt;
  logic [REF_W-1:0]        ref_cnt;
  logic [IDX_W-1:0]        index;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   operand;
  logic                    is_hex;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [4*NUM_DIGITS-1:0] buffer;
  logic                    ovf;
  logic [63:0]             digit_src;
  logic                    capture;
  logic                    advance;
  logic                    higher_zero;
  logic [4:0]              code;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    return 7'b0000001;
      5'd1:    return 7'b1001111;
      5'd2:    return 7'b0010010;
      5'd3:    return 7'b0000110;
      5'd4:    return 7'b1001100;
      5'd5:    return 7'b0100100;
      5'd6:    return 7'b0100000;
      5'd7:    return 7'b0001111;
      5'd8:    return 7'b0000000;
      5'd9:    return 7'b0000100;
      5'd10:   return 7'b0001000;
      5'd11:   return 7'b1100000;
      5'd12:   return 7'b0110001;
      5'd13:   return 7'b1000010;
      5'd14:   return 7'b0110000;
      5'd15:   return 7'b0111000;
      G_S:     return 7'b0100100;
      G_T:     return 7'b1110000;
      G_O:     return 7'b1100010;
      G_P:     return 7'b0011000;
      G_DASH:  return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  assign capture   = (upd_cnt == UPD_W'(UPDATE_DIV - 1));
  assign advance   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
  assign digit_src = is_hex ? 64'(operand) : 64'(bcd);

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      upd_cnt <= '0;
      state   <= IDLE;
      operand <= '0;
      is_hex  <= 1'b0;
      bcd     <= '0;
      cnt     <= '0;
      // NOTE: the display buffer is a packed vector, so one assignment clears it on reset.
      buffer  <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      upd_cnt <= capture ? '0 : upd_cnt + 1'b1;
      case (state)
        IDLE: if (capture) begin
          operand <= result;
          is_hex  <= hex_mode;
          bcd     <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          state   <= hex_mode ? COMMIT : CONVERT;
        end
        CONVERT: begin
          {bcd, operand} <= {bcd_adj, operand} << 1;
          cnt            <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          buffer <= digit_src[4*NUM_DIGITS-1:0];
          ovf    <= |digit_src[63:4*NUM_DIGITS];
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Halt message beats leading-zero blanking, which beats the buffered digit.
  always_comb begin
    higher_zero = !ovf;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(index) && buffer[4*j +: 4] != 4'd0) higher_zero = 1'b0;
    end
    if (hlt && !test) begin
      case (int'(index))
        0:       code = G_P;
        1:       code = G_O;
        2:       code = G_T;
        3:       code = G_S;
        default: code = G_BLANK;
      endcase
    end else if (blank_lz && higher_zero && index != '0) begin
      code = G_BLANK;
    end else if (ovf) begin
      code = G_DASH;
    end else begin
      code = {1'b0, buffer[4*index +: 4]};
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      ref_cnt        <= '0;
      index          <= '0;
      Anode_Activate <= ~NUM_DIGITS'(1);
      LED_out        <= 7'b0000001;
    end else begin
      ref_cnt <= advance ? '0 : ref_cnt + 1'b1;
      if (advance) index <= (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
      Anode_Activate <= ~(NUM_DIGITS'(1) << index);
      LED_out        <= glyph(code);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl: directed and randomized values
// compared against an arithmetic model of the displayed digits.
module tb_sevenseg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 16;
  localparam int RD = 4;
  localparam int UD = 64;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] L_S = 7'b0100100;
  localparam logic [6:0] L_T = 7'b1110000;
  localparam logic [6:0] L_O = 7'b1100010;
  localparam logic [6:0] L_P = 7'b0011000;
  localparam logic [6:0] L_DASH  = 7'b1111110;
  localparam logic [6:0] L_BLANK = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] result = '0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic          hlt = 1'b0;
  logic          test = 1'b0;
  logic          busy;
  logic [ND-1:0] Anode_Activate;
  logic [6:0]    LED_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(ND), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .UPDATE_DIV(UD)
  ) dut (
    .clock_100Mhz(clk), .reset(reset), .result(result), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .hlt(hlt), .test(test), .busy(busy),
    .Anode_Activate(Anode_Activate), .LED_out(LED_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_capture();
    do tick(); while (cyc % UD != 0);
  endtask

  // Expected cathodes for digit i, straight from the display rules.
  function automatic logic [6:0] model_led(input int unsigned val, input bit hx, input int i,
                                           input bit blz, input bit h, input bit t);
    int unsigned base = hx ? 16 : 10;
    int unsigned pw   = 1;
    int unsigned lim  = 1;
    for (int j = 0; j < ND; j++) begin
      if (j < i) pw = pw * base;
      lim = lim * base;
    end
    if (h && !t) return (i == 3) ? L_S : (i == 2) ? L_T : (i == 1) ? L_O : L_P;
    if (val >= lim) return L_DASH;
    if (blz && i != 0 && val < pw) return L_BLANK;
    return GLYPH[(val / pw) % base];
  endfunction

  task automatic check_display(input int unsigned val, input bit hx, input string tag);
    logic [ND-1:0] pat;
    int            k;
    for (int i = 0; i < ND; i++) begin
      pat = ~(4'b0001 << i);
      k   = 0;
      do begin tick(); k++; end while (Anode_Activate !== pat && k < 4 * RD + 2);
      check($sformatf("%s_anode%0d", tag, i), 32'(Anode_Activate), 32'(pat));
      check($sformatf("%s_led%0d", tag, i), 32'(LED_out),
            32'(model_led(val, hx, i, blank_lz, hlt, test)));
    end
  endtask

  task automatic convert(input int unsigned val, input bit hx, input string tag);
    int n;
    result   = DW'(val);
    hex_mode = hx;
    wait_capture();
    check($sformatf("%s_busy_rise", tag), 32'(busy), 32'd1);
    result = DW'($urandom);
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      tick();
      if (busy === 1'b1) n++;
    end
    check($sformatf("%s_busy_len", tag), 32'(n), hx ? 32'd1 : 32'(DW + 1));
    result = DW'(val);
    check_display(val, hx, tag);
  endtask

  initial begin
    int unsigned v;
    bit          hx;

    repeat (3) @(negedge clk);
    check("rst_anode", 32'(Anode_Activate), 32'b1110);
    check("rst_led", 32'(LED_out), 32'b0000001);
    check("rst_busy", 32'(busy), 32'd0);

    reset = 1'b0;
    cyc   = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("scan_anode_%0d", k), 32'(Anode_Activate),
            32'(4'(~(4'b0001 << (((k - 1) / RD) % ND)))));
      check($sformatf("scan_led_%0d", k), 32'(LED_out), 32'b0000001);
    end

    convert(1234, 1'b0, "dec1234");
    convert(16'hBEEF, 1'b1, "hexbeef");
    convert(12345, 1'b0, "ovf12345");

    blank_lz = 1'b1;
    convert(7, 1'b0, "lz7_on");
    blank_lz = 1'b0;
    check_display(7, 1'b0, "lz7_off");

    convert(4096, 1'b0, "dec4096");
    hlt = 1'b1;
    check_display(4096, 1'b0, "halt");
    test = 1'b1;
    check_display(4096, 1'b0, "halt_test");
    hlt  = 1'b0;
    test = 1'b0;

    for (int r = 0; r < 10; r++) begin
      hx       = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      v        = (r % 3 == 0) ? $urandom_range(0, 999) : $urandom_range(0, 65535);
      convert(v, hx, $sformatf("rand%0d", r));
    end

    blank_lz = 1'b0;
    result   = 16'd4321;
    hex_mode = 1'b0;
    wait_capture();
    repeat (5) tick();
    check("midconv_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_anode", 32'(Anode_Activate), 32'b1110);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    check_display(0, 1'b0, "after_rst");
    check("after_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
